adc_sample_sequencer: RTL and testbench
=======================================

ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

Interface
REQ-001 The block SHALL have parameter SCLK_DIV, default 4: SCLK half-period in clk cycles; legal range ≥2.
REQ-002 The block SHALL have parameter SAMPLE_PERIOD, default 50_000: clk cycles between sequence starts (1 ms at 50 MHz).
REQ-003 The block SHALL have parameter CS_GAP, default 4: clk cycles adc_cs_n is held high between the two frames of a sequence.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port enable, input, 1 bit: periodic sampling enable.
REQ-007 The block SHALL have port adc_miso, input, 1 bit: ADC serial data.
REQ-008 The block SHALL have port adc_sclk, output, 1 bit: SPI clock, mode 0, idle low.
REQ-009 The block SHALL have port adc_cs_n, output, 1 bit: ADC chip select, active-low.
REQ-010 The block SHALL have port adc_mosi, output, 1 bit: command bit.
REQ-011 The block SHALL have port voltage, output, 16 bits unsigned: latest pack-voltage code.
REQ-012 The block SHALL have port current, output, 16 bits signed: latest current code in 0.1 A units; positive means charging.
REQ-013 The block SHALL have port sample_valid, output, 1 bit: one-cycle pulse when voltage and current update.
REQ-014 The block SHALL have port busy, output, 1 bit: high from sequence start through the publish cycle.

Function
REQ-015 The period counter SHALL hold at 0 while enable=0, count clk cycles while enable=1, and wrap to 0 at SAMPLE_PERIOD-1, issuing a start.
REQ-016 A start SHALL launch a sequence when the FSM is in IDLE; a start arriving while busy SHALL be dropped, with no queueing.
REQ-017 The FSM SHALL have states IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP and PUBLISH.
REQ-018 The FSM transitions SHALL be: IDLE→CS_SETUP(ch0)→SHIFT→CS_HOLD→GAP→CS_SETUP(ch1)→SHIFT→CS_HOLD→PUBLISH→IDLE.
REQ-019 CS_SETUP SHALL drive adc_cs_n low and adc_sclk low for SCLK_DIV cycles.
REQ-020 SHIFT SHALL generate 16 SCLK periods, each SCLK_DIV cycles high followed by SCLK_DIV cycles low.
REQ-021 In SHIFT, adc_miso SHALL be sampled on the clk cycle of each SCLK rising edge, MSB first, into a 16-bit shift register.
REQ-022 adc_mosi SHALL present command bit 15 (channel select: 0=voltage, 1=current) from CS_SETUP until the first falling edge, and SHALL be 0 for the remaining bits.
REQ-023 The ADC SHALL return, in the same frame, the conversion of the channel addressed in that frame.
REQ-024 CS_HOLD SHALL keep adc_cs_n low and adc_sclk low for SCLK_DIV cycles, then drive adc_cs_n high.
REQ-025 GAP SHALL keep adc_cs_n high for CS_GAP cycles.
REQ-026 Frame length SHALL be 34*SCLK_DIV cycles with adc_cs_n low.
REQ-027 With the default parameters, taking T as the cycle adc_cs_n first falls: ch0 adc_cs_n SHALL be low for T..T+135; ch1 adc_cs_n SHALL be low for T+140..T+275; PUBLISH SHALL occur at T+276.
REQ-028 At PUBLISH, voltage SHALL be loaded with the raw ch0 word unchanged.
REQ-029 At PUBLISH, current SHALL be loaded with the ch1 word converted from offset-binary to two's complement by inverting bit 15.
REQ-030 The ch0 word SHALL be held internally and not exposed until PUBLISH.
REQ-031 At PUBLISH, voltage, current and sample_valid SHALL all update in that same cycle.
REQ-032 Outputs SHALL hold their values between PUBLISH events.
REQ-033 If enable falls mid-sequence, the sequence SHALL complete and publish, and no further start SHALL occur.
REQ-034 If enable rises again, the first start SHALL occur SAMPLE_PERIOD cycles later.
REQ-035 SAMPLE_PERIOD SHALL be ≥ 2*(34*SCLK_DIV)+CS_GAP+2; smaller values are illegal configurations and are not required to work.

Reset
REQ-036 rst_n low SHALL asynchronously force adc_cs_n=1, adc_sclk=0, adc_mosi=0, voltage=0, current=0, sample_valid=0, busy=0, FSM=IDLE, and all counters and shift registers to 0.
REQ-037 Reset mid-frame SHALL abort the frame with no partial publish.
REQ-038 After rst_n deasserts, the first start SHALL occur SAMPLE_PERIOD cycles after enable is seen high.

Structure
REQ-039 Package bms_adc_pkg SHALL hold the FSM state enum, the channel codes CH_VOLTAGE=0 and CH_CURRENT=1, the frame width 16, and the default SCLK_DIV, SAMPLE_PERIOD and CS_GAP.
REQ-040 Sub-module spi_frame_engine SHALL run one 16-bit frame (CS_SETUP/SHIFT/CS_HOLD) with a start/done handshake and a channel input; the sequencer FSM SHALL instantiate it once.

Verification
REQ-041 Scenario: ADC model returns ch0=0x8000 and ch1=0x8000 → voltage=0x8000, current=0x0000, one sample_valid pulse at T+276.
REQ-042 Scenario: ch1 raw=0x0000 then 0xFFFF on successive sequences → current=0x8000 (-32768), then 0x7FFF.
REQ-043 Scenario: protocol monitor → exactly 16 SCLK rising edges per frame, SCLK high/low 4/4 cycles, adc_mosi bit15 = 0 in frame 1 and 1 in frame 2, adc_cs_n high for 4 cycles between frames.
REQ-044 Scenario: enable held high for 3 periods → sample_valid pulses exactly 50_000 cycles apart, busy low between sequences.
REQ-045 Scenario: enable dropped at T+50 → sequence publishes at T+276, and no adc_cs_n activity follows for 2*SAMPLE_PERIOD cycles.
REQ-046 Scenario: rst_n asserted at T+200 → adc_cs_n=1, adc_sclk=0 and all outputs 0 immediately, with no sample_valid; after release, normal sequences resume.

Source files
------------

// File: rtl/bms_adc_pkg.sv
// rtl/bms_adc_pkg.sv - shared types and defaults for the BMS ADC sample sequencer
package bms_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP,
    PUBLISH
  } state_t;

  localparam logic CH_VOLTAGE = 1'b0;
  localparam logic CH_CURRENT = 1'b1;

  localparam int FRAME_W = 16;

  localparam int DEF_SCLK_DIV      = 4;
  localparam int DEF_SAMPLE_PERIOD = 50_000;
  localparam int DEF_CS_GAP        = 4;

  // The current channel is offset-binary; flipping the MSB yields two's complement.
  function automatic logic [FRAME_W-1:0] offset_to_twos(input logic [FRAME_W-1:0] w);
    return {~w[FRAME_W-1], w[FRAME_W-2:0]};
  endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// rtl/spi_frame_engine.sv - one 16-bit SPI mode-0 frame: chip-select setup, shift, hold
module spi_frame_engine
  import bms_adc_pkg::*;
#(
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               channel,
  input  logic               miso,
  output logic               sclk,
  output logic               cs_n,
  output logic               mosi,
  output logic               done,
  output state_t             phase,
  output logic [FRAME_W-1:0] data
);

  localparam int CW = $clog2(2 * SCLK_DIV + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * SCLK_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_W - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;

  // miso is captured on the clk edge that raises sclk, i.e. at the end of each low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      data    <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      case (phase)
        IDLE: if (start) begin
          phase <= CS_SETUP;
          cnt   <= '0;
          cs_n  <= 1'b0;
          sclk  <= 1'b0;
          mosi  <= channel;
        end
        CS_SETUP: if (cnt == HALF_LAST) begin
          phase   <= SHIFT;
          cnt     <= '0;
          bit_cnt <= '0;
          sclk    <= 1'b1;
          data    <= {data[FRAME_W-2:0], miso};
        end else begin
          cnt <= cnt + 1'b1;
        end
        SHIFT: begin
          if (cnt == HALF_LAST) begin
            sclk <= 1'b0;
            mosi <= 1'b0;
            cnt  <= cnt + 1'b1;
          end else if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              phase <= CS_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sclk    <= 1'b1;
              data    <= {data[FRAME_W-2:0], miso};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CS_HOLD: if (cnt == HALF_LAST) begin
          phase <= IDLE;
          cnt   <= '0;
          cs_n  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: phase <= IDLE;
      endcase
    end
  end

  assign done = (phase == CS_HOLD) && (cnt == HALF_LAST);

endmodule

// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - periodic two-channel (voltage, current) ADC sampling sequencer
module adc_sample_sequencer
  import bms_adc_pkg::*;
#(
  parameter int SCLK_DIV      = DEF_SCLK_DIV,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int CS_GAP        = DEF_CS_GAP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               adc_miso,
  output logic               adc_sclk,
  output logic               adc_cs_n,
  output logic               adc_mosi,
  output logic [15:0]        voltage,
  output logic signed [15:0] current,
  output logic               sample_valid,
  output logic               busy
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(CS_GAP - 1);

  logic [PW-1:0]      period_cnt;
  logic               period_start;
  state_t             state;
  logic [GW-1:0]      gap_cnt;
  logic               frame_ch;
  logic [FRAME_W-1:0] ch0_word;

  logic               eng_start;
  logic               eng_chan;
  logic               eng_done;
  state_t             eng_phase;
  logic [FRAME_W-1:0] eng_data;

  assign period_start = enable && (period_cnt == PERIOD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (!enable || period_start) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Frames are launched combinationally so the engine's chip-select lines up with the FSM cycle.
  assign eng_start = ((state == IDLE) && period_start) ||
                     ((state == GAP) && (gap_cnt == GAP_LAST));
  assign eng_chan  = (state == GAP) ? CH_CURRENT : CH_VOLTAGE;

  spi_frame_engine #(
    .SCLK_DIV(SCLK_DIV)
  ) u_engine (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (eng_start),
    .channel(eng_chan),
    .miso   (adc_miso),
    .sclk   (adc_sclk),
    .cs_n   (adc_cs_n),
    .mosi   (adc_mosi),
    .done   (eng_done),
    .phase  (eng_phase),
    .data   (eng_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      frame_ch     <= CH_VOLTAGE;
      ch0_word     <= '0;
      voltage      <= '0;
      current      <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: if (period_start) begin
          state    <= CS_SETUP;
          frame_ch <= CH_VOLTAGE;
          busy     <= 1'b1;
        end
        CS_SETUP: if (eng_phase == SHIFT) state <= SHIFT;
        SHIFT:    if (eng_phase == CS_HOLD) state <= CS_HOLD;
        CS_HOLD: if (eng_done) begin
          if (frame_ch == CH_VOLTAGE) begin
            ch0_word <= eng_data;
            gap_cnt  <= '0;
            state    <= GAP;
          end else begin
            voltage      <= ch0_word;
            current      <= offset_to_twos(eng_data);
            sample_valid <= 1'b1;
            state        <= PUBLISH;
          end
        end
        GAP: if (gap_cnt == GAP_LAST) begin
          state    <= CS_SETUP;
          frame_ch <= CH_CURRENT;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        PUBLISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb/tb_adc_sample_sequencer.sv - self-checking bench with an ADC model and protocol monitor
module tb_adc_sample_sequencer;

  localparam int SCLK_DIV  = 4;
  localparam int SP        = 400;
  localparam int CS_GAP    = 4;
  localparam int FRAME_CYC = 34 * SCLK_DIV;
  localparam int PUB_OFS   = 2 * FRAME_CYC + CS_GAP;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               adc_miso = 1'b0;
  logic               adc_sclk;
  logic               adc_cs_n;
  logic               adc_mosi;
  logic [15:0]        voltage;
  logic signed [15:0] current;
  logic               sample_valid;
  logic               busy;

  adc_sample_sequencer #(
    .SCLK_DIV     (SCLK_DIV),
    .SAMPLE_PERIOD(SP),
    .CS_GAP       (CS_GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .adc_miso    (adc_miso),
    .adc_sclk    (adc_sclk),
    .adc_cs_n    (adc_cs_n),
    .adc_mosi    (adc_mosi),
    .voltage     (voltage),
    .current     (current),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] ch0_val = '0;
  logic [15:0] ch1_val = '0;

  int fall_q[$];
  int low_q[$];
  int rise_q[$];
  int gap_q[$];
  int sv_q[$];
  logic mosi_q[$];

  logic [15:0] frame_word = '0;
  int bit_idx = 16;
  int rises = 0, low_run = 0, high_run = 0, cs_high_run = 0, fall_cyc = 0;
  int cs_falls = 0, sv_total = 0;
  int sclk_bad = 0, mosi_bad = 0, busy_bad = 0, sv_wide = 0;
  logic saw_fall = 1'b0, in_seq = 1'b0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_sv = 1'b0;

  // ADC model (answers the channel addressed by the frame's command bit) plus protocol monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_sv = 1'b0; in_seq = 1'b0;
      cs_high_run = 0; bit_idx = 16; adc_miso = 1'b0;
    end else begin
      if (prev_cs && !adc_cs_n) begin
        fall_q.push_back(cyc);
        mosi_q.push_back(adc_mosi);
        if (adc_mosi) gap_q.push_back(cs_high_run);
        else in_seq = 1'b1;
        frame_word = adc_mosi ? ch1_val : ch0_val;
        bit_idx = 0; rises = 0; saw_fall = 1'b0; low_run = 0; high_run = 0;
        fall_cyc = cyc; cs_high_run = 0;
        cs_falls++;
      end
      if (!prev_cs && adc_cs_n) begin
        low_q.push_back(cyc - fall_cyc);
        rise_q.push_back(rises);
      end
      if (!adc_cs_n) begin
        if (adc_sclk && !prev_sclk) begin
          rises++;
          if (low_run != SCLK_DIV) sclk_bad++;
          low_run = 0;
        end
        if (!adc_sclk && prev_sclk) begin
          if (high_run != SCLK_DIV) sclk_bad++;
          high_run = 0;
          bit_idx++;
          saw_fall = 1'b1;
        end
        if (adc_sclk) high_run++;
        else low_run++;
        if (saw_fall && adc_mosi) mosi_bad++;
      end else begin
        cs_high_run++;
        if (adc_sclk) sclk_bad++;
      end
      if (sample_valid) begin
        sv_q.push_back(cyc);
        sv_total++;
        if (prev_sv) sv_wide++;
      end
      if (busy !== in_seq) busy_bad++;
      if (sample_valid) in_seq = 1'b0;
      adc_miso = (!adc_cs_n && bit_idx < 16) ? frame_word[15 - bit_idx] : 1'b0;
      prev_cs = adc_cs_n; prev_sclk = adc_sclk; prev_sv = sample_valid;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    fall_q.delete(); low_q.delete(); rise_q.delete();
    gap_q.delete(); sv_q.delete(); mosi_q.delete();
  endtask

  // One full sequence: values the ADC returns, expected first chip-select fall, optional enable drop.
  task automatic do_seq(input logic [15:0] v, input logic [15:0] c, input int exp_t,
                        input int prev_sv_cyc, input int drop_at,
                        output int t_out, output int sv_out);
    int n;
    logic [15:0] exp_cur;
    clear_q();
    ch0_val = v;
    ch1_val = c;
    exp_cur = 16'(int'(c) - 32768);
    n = 0;
    while (sv_q.size() == 0 && n < SP + 400) begin
      @(negedge clk); #1; n++;
      if (drop_at >= 0 && fall_q.size() > 0 && cyc == fall_q[0] + drop_at) enable = 1'b0;
    end
    check("publish_seen", sv_q.size(), 1);
    t_out  = (fall_q.size() > 0) ? fall_q[0] : -1;
    sv_out = (sv_q.size() > 0) ? sv_q[0] : -1;
    @(negedge clk); #1;
    check("sv_one_cycle", sample_valid, 0);
    check("sv_count", sv_q.size(), 1);
    check("start_cycle", t_out, exp_t);
    check("publish_cycle", sv_out, t_out + PUB_OFS);
    if (prev_sv_cyc >= 0) check("sv_period", sv_out - prev_sv_cyc, SP);
    check("voltage", voltage, v);
    check("current", $unsigned(current), exp_cur);
    check("frames", fall_q.size(), 2);
    if (fall_q.size() == 2 && low_q.size() == 2 && rise_q.size() == 2 &&
        mosi_q.size() == 2 && gap_q.size() == 1) begin
      check("ch1_start", fall_q[1], t_out + FRAME_CYC + CS_GAP);
      check("frame0_len", low_q[0], FRAME_CYC);
      check("frame1_len", low_q[1], FRAME_CYC);
      check("frame0_rises", rise_q[0], 16);
      check("frame1_rises", rise_q[1], 16);
      check("frame0_cmd", mosi_q[0], 0);
      check("frame1_cmd", mosi_q[1], 1);
      check("cs_gap", gap_q[0], CS_GAP);
    end
  endtask

  initial begin
    int t, s, en_cyc, rel, n, falls0, sv0;
    logic [15:0] rv, rc;
    t = 0; s = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_cs_n", adc_cs_n, 1);
    check("reset_sclk", adc_sclk, 0);
    check("reset_mosi", adc_mosi, 0);
    check("reset_voltage", voltage, 0);
    check("reset_current", $unsigned(current), 0);
    check("reset_sv", sample_valid, 0);
    check("reset_busy", busy, 0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("idle_no_frames", cs_falls, 0);

    @(negedge clk);
    en_cyc = cyc;
    enable = 1'b1;
    do_seq(16'h8000, 16'h8000, en_cyc + SP, -1, -1, t, s);
    do_seq(16'h3C5A, 16'h0000, t + SP, s, -1, t, s);
    do_seq(16'hC3A5, 16'hFFFF, t + SP, s, -1, t, s);
    for (int i = 0; i < 4; i++) begin
      rv = 16'($urandom());
      rc = 16'($urandom());
      do_seq(rv, rc, t + SP, s, -1, t, s);
    end

    do_seq(16'h1234, 16'hABCD, t + SP, s, 50, t, s);
    falls0 = cs_falls;
    sv0 = sv_total;
    repeat (2 * SP) @(negedge clk);
    #1;
    check("quiet_after_drop", cs_falls - falls0, 0);
    check("no_sv_after_drop", sv_total - sv0, 0);

    @(negedge clk);
    en_cyc = cyc;
    enable = 1'b1;
    clear_q();
    n = 0;
    while (fall_q.size() == 0 && n < SP + 50) begin
      @(negedge clk); #1; n++;
    end
    t = (fall_q.size() > 0) ? fall_q[0] : -1;
    check("restart_start", t, en_cyc + SP);
    while (cyc < t + 200) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", adc_cs_n, 1);
    check("abort_sclk", adc_sclk, 0);
    check("abort_mosi", adc_mosi, 0);
    check("abort_voltage", voltage, 0);
    check("abort_current", $unsigned(current), 0);
    check("abort_sv", sample_valid, 0);
    check("abort_busy", busy, 0);
    sv0 = sv_total;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    do_seq(16'h0FED, 16'h8001, rel + SP, -1, -1, t, s);
    check("no_partial_publish", sv_total - sv0, 1);

    check("sclk_timing_faults", sclk_bad, 0);
    check("mosi_after_cmd_faults", mosi_bad, 0);
    check("busy_window_faults", busy_bad, 0);
    check("sv_wide_pulses", sv_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
